// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe: input beat, output result and flags.
// master drives operands and out_ready; slave is the adder.
interface fp_add_pipe_if #(
    parameter int WA = 16,
    parameter int WB = 16,
    parameter int WC = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic          a_signed;
    logic [WB-1:0] b;
    logic          b_signed;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [WC-1:0] c;
    logic          c_signed;
    logic          ovf;
    logic          unf;

    modport master (
        output in_valid, a, a_signed, b, b_signed, sub, out_ready,
        input  in_ready, out_valid, c, c_signed, ovf, unf
    );

    modport slave (
        input  in_valid, a, a_signed, b, b_signed, sub, out_ready,
        output in_ready, out_valid, c, c_signed, ovf, unf
    );
endinterface

// File: rtl/fp_add_pipe.sv
// Two-stage fixed-point add/sub: align in S1, add/requantise/clamp in S2, with saturation counter.
// Define FP_ADD_PIPE_ROUND_EN for half-up rounding when the output fraction is narrower.
module fp_add_pipe #(
    parameter int I1    = 2,
    parameter int F1    = 14,
    parameter int I2    = 2,
    parameter int F2    = 14,
    parameter int I3    = 2,
    parameter int F3    = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_add_pipe_if.slave     bus,
    input  logic             sat_cnt_clr,
    output logic [CNT_W-1:0] sat_cnt
);
    localparam int WA = I1 + F1;
    localparam int WB = I2 + F2;
    localparam int IM = (I1 > I2) ? I1 : I2;
    localparam int F  = (F1 > F2) ? F1 : F2;
    localparam int W  = IM + 2 + F;
    localparam int W1 = W + 1;
    localparam int N  = I3 + F3;
    localparam int QW = (F3 >= F) ? W + F3 - F : W1 - (F - F3);
    localparam int CW = ((QW > N) ? QW : N) + 2;

    localparam logic signed [CW-1:0] ONE  = 1;
    localparam logic signed [CW-1:0] SMAX = (ONE <<< (N - 1)) - ONE;
    localparam logic signed [CW-1:0] SMIN = -(ONE <<< (N - 1));
    localparam logic signed [CW-1:0] UMAX = (ONE <<< N) - ONE;
    localparam logic signed [CW-1:0] UMIN = '0;

    logic                    s1_valid_reg;
    logic                    s1_sub_reg;
    logic                    s1_csig_reg;
    logic signed [W-1:0]     s1_a_reg;
    logic signed [W-1:0]     s1_b_reg;
    logic signed [W-1:0]     a_ext;
    logic signed [W-1:0]     b_ext;
    logic signed [W-1:0]     sum;
    logic signed [QW-1:0]    q;
    logic signed [CW-1:0]    q_ext;
    logic signed [CW-1:0]    max_v;
    logic signed [CW-1:0]    min_v;
    logic                    ovf_next;
    logic                    unf_next;
    logic [N-1:0]            c_next;

    logic                    out_valid_reg;
    logic                    c_signed_reg;
    logic                    ovf_reg;
    logic                    unf_reg;
    logic [N-1:0]            c_reg;
    logic [CNT_W-1:0]        sat_cnt_reg;
    logic [CNT_W-1:0]        sat_cnt_next;
    logic                    s2_load;
    logic                    in_ready;

    assign s2_load  = !out_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_load;

    // Sign- or zero-extend to the common internal format, zero-pad the fraction LSBs.
    always_comb begin
        a_ext = (bus.a_signed ? {{(W - WA){bus.a[WA-1]}}, bus.a}
                              : {{(W - WA){1'b0}}, bus.a}) <<< (F - F1);
        b_ext = (bus.b_signed ? {{(W - WB){bus.b[WB-1]}}, bus.b}
                              : {{(W - WB){1'b0}}, bus.b}) <<< (F - F2);
        sum   = s1_sub_reg ? (s1_a_reg - s1_b_reg) : (s1_a_reg + s1_b_reg);
    end

    generate
        if (F3 >= F) begin : g_widen
            assign q = QW'(sum) <<< (F3 - F);
        end else begin : g_narrow
            logic signed [W1-1:0] r;
`ifdef FP_ADD_PIPE_ROUND_EN
            // Half-up: one extra bit of headroom so the rounding carry can reach the clamp.
            assign r = W1'(sum) + (W1'(1) <<< (F - F3 - 1));
`else
            assign r = W1'(sum);
`endif
            assign q = QW'(r >>> (F - F3));
        end
    endgenerate

    always_comb begin
        q_ext    = CW'(q);
        max_v    = s1_csig_reg ? SMAX : UMAX;
        min_v    = s1_csig_reg ? SMIN : UMIN;
        ovf_next = q_ext > max_v;
        unf_next = q_ext < min_v;
        if (ovf_next) begin
            c_next = max_v[N-1:0];
        end else if (unf_next) begin
            c_next = min_v[N-1:0];
        end else begin
            c_next = q_ext[N-1:0];
        end
    end

    always_comb begin
        sat_cnt_next = sat_cnt_reg;
        if (sat_cnt_clr) begin
            sat_cnt_next = '0;
        end else if (out_valid_reg && bus.out_ready && (ovf_reg || unf_reg) && !(&sat_cnt_reg)) begin
            sat_cnt_next = sat_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sub_reg    <= 1'b0;
            s1_csig_reg   <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            out_valid_reg <= 1'b0;
            c_signed_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            c_reg         <= '0;
            sat_cnt_reg   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_reg    <= a_ext;
                    s1_b_reg    <= b_ext;
                    s1_sub_reg  <= bus.sub;
                    s1_csig_reg <= bus.a_signed | bus.b_signed | bus.sub;
                end
            end
            // Result register holds while stalled so c stays stable under backpressure.
            if (s2_load) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    c_reg        <= c_next;
                    c_signed_reg <= s1_csig_reg;
                    ovf_reg      <= ovf_next;
                    unf_reg      <= unf_next;
                end
            end
            sat_cnt_reg <= sat_cnt_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.c         = c_reg;
    assign bus.c_signed  = c_signed_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.unf       = unf_reg;
    assign sat_cnt       = sat_cnt_reg;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: default Q2.14 instance plus an F3=12 instance fed the same beats.
// Honors FP_ADD_PIPE_ROUND_EN for the narrowing expectations.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sat_cnt_clr;
    logic [15:0] sat_cnt0;
    logic [15:0] sat_cnt12;
    int          checks = 0;
    int          errors = 0;

    fp_add_pipe_if #(.WA(16), .WB(16), .WC(16)) if0 ();
    fp_add_pipe_if #(.WA(16), .WB(16), .WC(14)) if12 ();

    assign if12.in_valid  = if0.in_valid;
    assign if12.a         = if0.a;
    assign if12.a_signed  = if0.a_signed;
    assign if12.b         = if0.b;
    assign if12.b_signed  = if0.b_signed;
    assign if12.sub       = if0.sub;
    assign if12.out_ready = if0.out_ready;

    always #5 clk = ~clk;

    fp_add_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if0), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt0)
    );

    fp_add_pipe #(.F3(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .bus(if12), .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic [15:0] a, input logic as, input logic [15:0] b,
                            input logic bs, input logic sb);
        if0.a        = a;
        if0.a_signed = as;
        if0.b        = b;
        if0.b_signed = bs;
        if0.sub      = sb;
        if0.in_valid = 1'b1;
    endtask

    // One beat through an idle pipe with out_ready=1; returns with the result on the outputs.
    task automatic run(input string tag, input logic [15:0] a, input logic as, input logic [15:0] b,
                       input logic bs, input logic sb, input logic [15:0] exp_c,
                       input logic exp_cs, input logic exp_ovf, input logic exp_unf);
        set_beat(a, as, b, bs, sb);
        #1;
        chk({tag, "_in_ready"}, if0.in_ready, 1'b1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        chk({tag, "_lat1"}, if0.out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, if0.out_valid, 1'b1);
        chk({tag, "_c"}, if0.c, exp_c);
        chk({tag, "_csig"}, if0.c_signed, exp_cs);
        chk({tag, "_ovf"}, if0.ovf, exp_ovf);
        chk({tag, "_unf"}, if0.unf, exp_unf);
        $display("txn %s: a=%h b=%h sub=%b -> c=%h cs=%b ovf=%b unf=%b",
                 tag, a, b, sb, if0.c, if0.c_signed, if0.ovf, if0.unf);
    endtask

    initial begin
        int idx;
        int acc;
        logic [15:0] exp_c12;
        logic        exp_ovf12;

        rst_n         = 1'b0;
        sat_cnt_clr   = 1'b0;
        if0.in_valid  = 1'b0;
        if0.a         = '0;
        if0.a_signed  = 1'b0;
        if0.b         = '0;
        if0.b_signed  = 1'b0;
        if0.sub       = 1'b0;
        if0.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", if0.out_valid, 1'b0);
        chk("rst_c", if0.c, 16'h0000);
        chk("rst_csig", if0.c_signed, 1'b0);
        chk("rst_ovf", if0.ovf, 1'b0);
        chk("rst_unf", if0.unf, 1'b0);
        chk("rst_sat_cnt", sat_cnt0, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", if0.in_ready, 1'b1);

        // Unsigned add, in range
        run("t1", 16'h3000, 1'b0, 16'h4CCD, 1'b0, 1'b0, 16'h7CCD, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t1_drain", if0.out_valid, 1'b0);
        chk("t1_sat_cnt", sat_cnt0, 16'd0);

        // Unsigned overflow clamps to 0xFFFF
        run("t2", 16'hC000, 1'b0, 16'h8000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t2_sat_cnt", sat_cnt0, 16'd1);

        // Signed overflow and underflow
        run("t3a", 16'h4000, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run("t3b", 16'hC000, 1'b1, 16'hA000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t3_sat_cnt", sat_cnt0, 16'd3);

        // Subtraction makes the result signed; zero on the unsigned path; mixed-sign underflow
        run("t4a", 16'h2000, 1'b0, 16'h4000, 1'b0, 1'b1, 16'hE000, 1'b1, 1'b0, 1'b0);
        run("t4b", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("t4c", 16'h8000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t4_sat_cnt", sat_cnt0, 16'd4);

        // Clear on the same edge as a saturating delivery: clear wins
        run("clr", 16'hC000, 1'b0, 16'h8000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("clr_sat_cnt", sat_cnt0, 16'd0);
        @(posedge clk); #1;
        chk("clr_hold", sat_cnt0, 16'd0);

        // Backpressure: 4 beats offered with out_ready=0, only 2 fit
        if0.out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            set_beat(16'h1000 * 16'(idx + 1), 1'b0, 16'h0001, 1'b0, 1'b0);
            #1;
            if (if0.in_ready) begin
                idx++;
                acc++;
            end
            @(posedge clk); #1;
        end
        chk("t5_accepted", acc, 2);
        chk("t5_in_ready_low", if0.in_ready, 1'b0);
        chk("t5_held_c", if0.c, 16'h1001);
        if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (idx < 4) set_beat(16'h1000 * 16'(idx + 1), 1'b0, 16'h0001, 1'b0, 1'b0);
            else if0.in_valid = 1'b0;
            #1;
            chk("t5_out_valid", if0.out_valid, 1'b1);
            chk("t5_out_c", if0.c, 16'h1000 * 16'(i + 1) + 16'h0001);
            $display("txn t5[%0d]: c=%h", i, if0.c);
            if (if0.in_valid && if0.in_ready) idx++;
            @(posedge clk); #1;
        end
        if0.in_valid = 1'b0;
        chk("t5_all_sent", idx, 4);
        chk("t5_no_dup", if0.out_valid, 1'b0);

        // Narrowed output (F3=12): rounding vs truncation, and rounding carry into overflow
`ifdef FP_ADD_PIPE_ROUND_EN
        exp_c12 = 16'h0001;
`else
        exp_c12 = 16'h0000;
`endif
        run("t6a", 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("t6a_c12", if12.c, exp_c12);
        chk("t6a_ovf12", if12.ovf, 1'b0);
`ifdef FP_ADD_PIPE_ROUND_EN
        exp_ovf12 = 1'b1;
`else
        exp_ovf12 = 1'b0;
`endif
        run("t6b", 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("t6b_c12", if12.c, 16'h3FFF);
        chk("t6b_ovf12", if12.ovf, exp_ovf12);
        $display("txn t6b12: c=%h ovf=%b", if12.c, if12.ovf);

        // Reset with two beats in flight drops them and clears the counter
        run("t7", 16'hC000, 1'b0, 16'h8000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("t7_sat_cnt", sat_cnt0, 16'd1);
        if0.out_ready = 1'b0;
        set_beat(16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_beat(16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        chk("t7_inflight", if0.out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t7_rst_out_valid", if0.out_valid, 1'b0);
        chk("t7_rst_sat_cnt", sat_cnt0, 16'd0);
        chk("t7_rst_c", if0.c, 16'h0000);
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        #1;
        chk("t7_in_ready", if0.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t7_no_ghost", if0.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
